// File: rtl/dcm_prog_responder.sv
// Responder side of the DCM_CLKGEN programming port: parses LoadD/LoadM/GO frames,
// holds pending and active M-1/D-1 values, and drives PROGDONE through a GO.
//
// state    | meaning
// ST_IDLE  | waiting for PROGEN to rise; first bit is captured here
// ST_CMD   | second cycle: single-bit GO/error, or two-bit command decode
// ST_SHIFT | collecting 8 data bits, LSB first
// ST_END   | expecting PROGEN low to commit the loaded value
// ST_DRAIN | discarding the rest of a rejected frame
// ST_BUSY  | GO in progress, PROGDONE low, frames rejected
module dcm_prog_responder #(
  parameter logic [7:0] INITIAL_M_S1 = 8'd15,
  parameter logic [7:0] INITIAL_D_S1 = 8'd8,
  parameter int         GO_LATENCY   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcm_prog_en,
  input  logic        dcm_prog_data,
  output logic        dcm_prog_done,
  output logic [7:0]  m_s1,
  output logic [7:0]  d_s1,
  output logic [7:0]  pend_m_s1,
  output logic [7:0]  pend_d_s1,
  output logic        frame_error,
  output logic [15:0] go_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_SHIFT, ST_END, ST_DRAIN, ST_BUSY} state_t;

  localparam logic [7:0] LAT_M1 = 8'(GO_LATENCY - 1);

  state_t     state_q, state_n;
  logic       bit0_q;
  logic       is_m_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic [7:0] timer_q;
  logic       busy_seen_q;

  logic err_n, commit, go_start, shift_en;

  always_comb begin
    state_n  = state_q;
    err_n    = 1'b0;
    commit   = 1'b0;
    go_start = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: if (dcm_prog_en) state_n = ST_CMD;
      ST_CMD: begin
        if (!dcm_prog_en) begin
          if (!bit0_q) begin
            go_start = 1'b1;
            state_n  = ST_BUSY;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end else if (bit0_q) begin
          state_n = ST_SHIFT;
        end else begin
          err_n   = 1'b1;
          state_n = ST_DRAIN;
        end
      end
      ST_SHIFT: begin
        if (dcm_prog_en) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 3'd7) state_n = ST_END;
        end else begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_END: begin
        if (dcm_prog_en) begin
          err_n   = 1'b1;
          state_n = ST_DRAIN;
        end else begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DRAIN: if (!dcm_prog_en) state_n = ST_IDLE;
      ST_BUSY: begin
        // A frame overlapping the GO is flagged once and drained afterwards.
        if (dcm_prog_en && !busy_seen_q) err_n = 1'b1;
        if (timer_q == 8'd0) state_n = dcm_prog_en ? ST_DRAIN : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit0_q        <= 1'b0;
      is_m_q        <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 8'd0;
      timer_q       <= 8'd0;
      busy_seen_q   <= 1'b0;
      dcm_prog_done <= 1'b1;
      frame_error   <= 1'b0;
      go_count      <= 16'd0;
      m_s1          <= INITIAL_M_S1;
      d_s1          <= INITIAL_D_S1;
      pend_m_s1     <= INITIAL_M_S1;
      pend_d_s1     <= INITIAL_D_S1;
    end else begin
      state_q     <= state_n;
      frame_error <= err_n;
      if (state_q == ST_IDLE && dcm_prog_en) bit0_q <= dcm_prog_data;
      if (state_q == ST_CMD && dcm_prog_en) begin
        is_m_q    <= dcm_prog_data;
        bit_cnt_q <= 3'd0;
      end
      if (shift_en) begin
        shreg_q   <= {dcm_prog_data, shreg_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (commit) begin
        if (is_m_q) pend_m_s1 <= shreg_q;
        else        pend_d_s1 <= shreg_q;
      end
      busy_seen_q <= (state_q == ST_BUSY) && dcm_prog_en;
      if (go_start) begin
        dcm_prog_done <= 1'b0;
        m_s1          <= pend_m_s1;
        d_s1          <= pend_d_s1;
        go_count      <= go_count + 16'd1;
        timer_q       <= LAT_M1;
      end else if (state_q == ST_BUSY) begin
        if (timer_q == 8'd0) dcm_prog_done <= 1'b1;
        else                 timer_q <= timer_q - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed bench for dcm_prog_responder: one instance at GO_LATENCY=16 for frame
// handling, one at GO_LATENCY=1 for the go_count wrap.
module tb_dcm_prog_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, data = 1'b0;
  logic        en_w = 1'b0, data_w = 1'b0;
  logic        done, fe, done_w, fe_w;
  logic [7:0]  m_s1, d_s1, pend_m, pend_d, m_s1_w, d_s1_w, pend_m_w, pend_d_w;
  logic [15:0] go_count, go_count_w;

  int n_checks = 0;
  int n_err = 0;
  int err_pulses = 0;
  int err_double = 0;
  int done_low = 0;
  logic fe_prev = 1'b0;
  int e0, l0;

  always #5 clk = ~clk;

  dcm_prog_responder #(.INITIAL_M_S1(8'd15), .INITIAL_D_S1(8'd8), .GO_LATENCY(16)) dut (
    .clk(clk), .reset(reset), .dcm_prog_en(en), .dcm_prog_data(data),
    .dcm_prog_done(done), .m_s1(m_s1), .d_s1(d_s1), .pend_m_s1(pend_m),
    .pend_d_s1(pend_d), .frame_error(fe), .go_count(go_count));

  dcm_prog_responder #(.INITIAL_M_S1(8'd15), .INITIAL_D_S1(8'd8), .GO_LATENCY(1)) dut_w (
    .clk(clk), .reset(reset), .dcm_prog_en(en_w), .dcm_prog_data(data_w),
    .dcm_prog_done(done_w), .m_s1(m_s1_w), .d_s1(d_s1_w), .pend_m_s1(pend_m_w),
    .pend_d_s1(pend_d_w), .frame_error(fe_w), .go_count(go_count_w));

  always @(negedge clk) begin
    if (fe) err_pulses++;
    if (fe && fe_prev) err_double++;
    fe_prev = fe;
    if (!done) done_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic e, input logic d);
    en = e;
    data = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic send_load(input logic is_m, input logic [7:0] val);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, is_m);
    for (int i = 0; i < 8; i++) send_bit(1'b1, val[i]);
    send_bit(1'b0, 1'b0);
    idle(3);
  endtask

  task automatic send_go();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    do_reset();
    check("rst_m", m_s1, 8'h0F);
    check("rst_d", d_s1, 8'h08);
    check("rst_pend_m", pend_m, 8'h0F);
    check("rst_pend_d", pend_d, 8'h08);
    check("rst_done", done, 1'b1);
    check("rst_gocnt", go_count, 16'd0);
    idle(20);
    check("idle_done", done, 1'b1);
    check("idle_err", err_pulses, 0);

    // Basic load D, load M, GO with 16-cycle PROGDONE low
    send_load(1'b0, 8'h08);
    check("ld_pend_d", pend_d, 8'h08);
    send_load(1'b1, 8'h3F);
    check("ld_pend_m", pend_m, 8'h3F);
    check("ld_m_unapplied", m_s1, 8'h0F);
    l0 = done_low;
    send_go();
    check("go_done_low", done, 1'b0);
    check("go_m", m_s1, 8'h3F);
    check("go_d", d_s1, 8'h08);
    check("go_cnt", go_count, 16'd1);
    idle(15);
    check("go_done_still_low", done, 1'b0);
    idle(1);
    check("go_done_high", done, 1'b1);
    idle(3);
    check("go_low_cycles", done_low - l0, 16);
    check("go_no_err", err_pulses, 0);

    // Short LoadM frame: en drops after 5 data bits
    do_reset();
    e0 = err_pulses;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(3);
    check("short_err", err_pulses - e0, 1);
    check("short_pend_m", pend_m, 8'h0F);
    send_load(1'b1, 8'h20);
    check("after_short_pend_m", pend_m, 8'h20);

    // Overlong LoadM frame: en high for 11 cycles
    e0 = err_pulses;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(3);
    check("long_err", err_pulses - e0, 1);
    check("long_pend_m", pend_m, 8'h20);
    send_go();
    check("long_go_m", m_s1, 8'h20);
    check("long_go_d", d_s1, 8'h08);
    check("long_go_cnt", go_count, 16'd1);
    idle(18);
    check("long_done", done, 1'b1);

    // Last load wins; LoadM during BUSY is rejected
    send_load(1'b1, 8'h10);
    send_load(1'b1, 8'h22);
    check("twice_pend_m", pend_m, 8'h22);
    send_go();
    check("twice_go_m", m_s1, 8'h22);
    e0 = err_pulses;
    send_load(1'b1, 8'h05);
    idle(8);
    check("busy_err", err_pulses - e0, 1);
    check("busy_pend_m", pend_m, 8'h22);
    check("busy_done_back", done, 1'b1);
    check("busy_cnt", go_count, 16'd2);
    send_load(1'b0, 8'h7E);
    check("post_busy_pend_d", pend_d, 8'h7E);

    // Reset mid-BUSY
    send_go();
    idle(5);
    check("midbusy_done_low", done, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_done", done, 1'b1);
    check("midrst_m", m_s1, 8'h0F);
    check("midrst_d", d_s1, 8'h08);
    check("midrst_pend_d", pend_d, 8'h08);
    check("midrst_cnt", go_count, 16'd0);
    reset = 1'b0;
    idle(2);
    check("no_double_err", err_double, 0);

    // go_count wrap on the GO_LATENCY=1 instance
    for (int i = 0; i < 65536; i++) begin
      en_w = 1'b1; data_w = 1'b0; step();
      en_w = 1'b0; step();
      if (i == 0) check("w_done_low", done_w, 1'b0);
      step();
      if (i == 0) check("w_done_high", done_w, 1'b1);
      if (i == 65534) check("w_cnt_ffff", go_count_w, 16'hFFFF);
    end
    check("w_cnt_wrap", go_count_w, 16'd0);
    check("w_m", m_s1_w, 8'h0F);
    check("w_err", fe_w, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
